// File: rtl/bus_pkg.sv
// Shared definitions for the 8088-style bus cycle sequencer:
// status codes driven on s_n, the T-state enum and type-class helpers.
package bus_pkg;

   localparam logic [2:0] STS_INTA    = 3'b000;
   localparam logic [2:0] STS_IO_RD   = 3'b001;
   localparam logic [2:0] STS_IO_WR   = 3'b010;
   localparam logic [2:0] STS_HALT    = 3'b011;
   localparam logic [2:0] STS_FETCH   = 3'b100;
   localparam logic [2:0] STS_MEM_RD  = 3'b101;
   localparam logic [2:0] STS_MEM_WR  = 3'b110;
   localparam logic [2:0] STS_PASSIVE = 3'b111;

   typedef enum logic [2:0] {
      TI = 3'd0,
      T1 = 3'd1,
      T2 = 3'd2,
      T3 = 3'd3,
      TW = 3'd4,
      T4 = 3'd5
   } t_state_e;

   function automatic logic is_write(input logic [2:0] sts);
      return (sts == STS_IO_WR) || (sts == STS_MEM_WR);
   endfunction

   function automatic logic is_read(input logic [2:0] sts);
      return (sts == STS_INTA) || (sts == STS_IO_RD) ||
             (sts == STS_FETCH) || (sts == STS_MEM_RD);
   endfunction

endpackage

// File: rtl/bus_wait_timer.sv
// Wait-state timeout counter. Cleared while the sequencer is in T3,
// advanced on every TW cycle that sees ready low; expired flags the
// 255th consecutive such cycle. Only built with BUS_WAIT_TIMEOUT_EN.
module bus_wait_timer (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic tick,
   output logic expired
);

   logic [7:0] count;

   // Count consecutive not-ready wait states since the last T3.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (tick) begin
         count <= count + 8'd1;
      end
   end

   assign expired = tick && (count == 8'd254);

endmodule

// File: rtl/cpu_bus_sequencer.sv
// 8088 bus cycle sequencer: accepts one request at a time and walks the
// T1-T2-T3-(TW)*-T4 sequence, driving status, multiplexed AD and high
// address, and returning read data with a one-cycle completion pulse.
// Optional wait-state timeout: define BUS_WAIT_TIMEOUT_EN.
module cpu_bus_sequencer
   import bus_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [2:0]  req_type,
   input  logic [19:0] req_addr,
   input  logic [7:0]  req_wdata,
   input  logic        ready,
   output logic [2:0]  s_n,
   output logic [7:0]  ad_out,
   output logic        ad_oe,
   input  logic [7:0]  ad_in,
   output logic [11:0] a_hi,
   output logic        rsp_valid,
   output logic [7:0]  rsp_rdata,
   output logic        rsp_err
);

   t_state_e    state, state_next;
   logic [2:0]  lat_type;
   logic [19:0] lat_addr;
   logic [7:0]  lat_wdata;
   logic        rst_done;
   logic        accept;
   logic        timeout;
   logic        finishing;
   logic        lat_halt;

   // rst_done keeps req_ready low for the first clock after reset release,
   // so the earliest T1 is two clocks after deassertion.
   assign req_ready = rst_done && ((state == TI) || (state == T4));
   assign accept    = req_ready && req_valid && (req_type != STS_PASSIVE);
   assign rsp_valid = (state == T4);
   assign lat_halt  = (lat_type == STS_HALT);
   assign finishing = ((state == T3) || (state == TW)) && (state_next == T4);

`ifdef BUS_WAIT_TIMEOUT_EN
   bus_wait_timer u_wait_timer (
      .clk     (clk),
      .reset   (reset),
      .clear   (state == T3),
      .tick    ((state == TW) && !ready),
      .expired (timeout)
   );

   // Timeout error flag: set on a timed-out TW, cleared when a new cycle starts.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rsp_err <= 1'b0;
      end else if (accept) begin
         rsp_err <= 1'b0;
      end else if (timeout) begin
         rsp_err <= 1'b1;
      end
   end
`else
   assign timeout = 1'b0;
   assign rsp_err = 1'b0;
`endif

   // State register, request latch and post-reset gate.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= TI;
         rst_done  <= 1'b0;
         lat_type  <= STS_PASSIVE;
         lat_addr  <= '0;
         lat_wdata <= '0;
      end else begin
         state    <= state_next;
         rst_done <= 1'b1;
         if (accept) begin
            lat_type  <= req_type;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
         end
      end
   end

   // Response data: captured on the edge that leaves T3/TW for T4.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rsp_rdata <= '0;
      end else if (finishing) begin
         if (timeout) begin
            rsp_rdata <= 8'hFF;
         end else if (lat_halt) begin
            rsp_rdata <= 8'h00;
         end else if (is_read(lat_type)) begin
            rsp_rdata <= ad_in;
         end
      end
   end

   // Next-state logic and bus outputs decoded from the current T-state.
   always_comb begin
      state_next = state;
      s_n        = STS_PASSIVE;
      ad_oe      = 1'b0;
      ad_out     = '0;
      a_hi       = '0;
      case (state)
         TI: begin
            if (accept) state_next = T1;
         end
         T1: begin
            state_next = T2;
            s_n        = lat_type;
            ad_oe      = 1'b1;
            ad_out     = lat_addr[7:0];
            a_hi       = lat_addr[19:8];
         end
         T2, T3, TW: begin
            if (state == T2) begin
               state_next = T3;
            end else if (state == T3) begin
               state_next = (lat_halt || ready) ? T4 : TW;
            end else begin
               state_next = (ready || timeout) ? T4 : TW;
            end
            s_n  = lat_halt ? STS_PASSIVE : lat_type;
            a_hi = lat_addr[19:8];
            if (is_write(lat_type)) begin
               ad_oe  = 1'b1;
               ad_out = lat_wdata;
            end
         end
         T4: begin
            state_next = accept ? T1 : TI;
            a_hi       = lat_addr[19:8];
            if (is_write(lat_type)) begin
               ad_oe  = 1'b1;
               ad_out = lat_wdata;
            end
         end
         default: state_next = TI;
      endcase
   end

endmodule

// File: tb/tb_cpu_bus_sequencer.sv
// Directed bench for cpu_bus_sequencer. A cycle-indexed model of each bus
// transaction supplies expected outputs; one negedge process compares them.
module tb_cpu_bus_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  req_type;
   logic [19:0] req_addr;
   logic [7:0]  req_wdata;
   logic        ready;
   logic [2:0]  s_n;
   logic [7:0]  ad_out;
   logic        ad_oe;
   logic [7:0]  ad_in;
   logic [11:0] a_hi;
   logic        rsp_valid;
   logic [7:0]  rsp_rdata;
   logic        rsp_err;

   cpu_bus_sequencer dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_type  (req_type),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .ready     (ready),
      .s_n       (s_n),
      .ad_out    (ad_out),
      .ad_oe     (ad_oe),
      .ad_in     (ad_in),
      .a_hi      (a_hi),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0]  s_n;
      logic        ad_oe;
      logic [7:0]  ad_out;
      logic [11:0] a_hi;
      logic        rsp_valid;
      logic [7:0]  rsp_rdata;
      logic        rsp_err;
      logic        req_ready;
   } obs_t;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   obs_t exp_o;
   logic exp_on = 1'b0;
   logic [7:0] model_rdata = 8'h00;
   logic       model_err = 1'b0;

   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   function automatic obs_t idle_exp();
      obs_t o;
      o.s_n       = 3'b111;
      o.ad_oe     = 1'b0;
      o.ad_out    = 8'h00;
      o.a_hi      = 12'h000;
      o.rsp_valid = 1'b0;
      o.rsp_rdata = model_rdata;
      o.rsp_err   = model_err;
      o.req_ready = 1'b1;
      return o;
   endfunction

   // Expected outputs for clock i (0 = first clock, last = completion clock).
   function automatic obs_t cyc_exp(input logic [2:0] t, input logic [19:0] a,
                                    input logic [7:0] d, input logic [7:0] din,
                                    input int i, input int last);
      obs_t o;
      logic wr, hlt, rd;
      wr  = (t == 3'b010) || (t == 3'b110);
      hlt = (t == 3'b011);
      rd  = !wr && !hlt;
      if (i == last)      o.s_n = 3'b111;
      else if (hlt && i > 0) o.s_n = 3'b111;
      else                o.s_n = t;
      o.ad_oe     = (i == 0) || wr;
      o.ad_out    = (i == 0) ? a[7:0] : (wr ? d : 8'h00);
      o.a_hi      = a[19:8];
      o.rsp_valid = (i == last);
      o.req_ready = (i == last);
      o.rsp_err   = 1'b0;
      if (i == last) o.rsp_rdata = rd ? din : (hlt ? 8'h00 : model_rdata);
      else           o.rsp_rdata = model_rdata;
      return o;
   endfunction

   // Single compare process against the model expectation.
   always @(negedge clk) begin
      if (exp_on) begin
         check("s_n",       32'(s_n),       32'(exp_o.s_n));
         check("ad_oe",     32'(ad_oe),     32'(exp_o.ad_oe));
         check("ad_out",    32'(ad_out),    32'(exp_o.ad_out));
         check("a_hi",      32'(a_hi),      32'(exp_o.a_hi));
         check("rsp_valid", 32'(rsp_valid), 32'(exp_o.rsp_valid));
         check("rsp_rdata", 32'(rsp_rdata), 32'(exp_o.rsp_rdata));
         check("rsp_err",   32'(rsp_err),   32'(exp_o.rsp_err));
         check("req_ready", 32'(req_ready), 32'(exp_o.req_ready));
      end
   end

   // One bus transaction; w = number of wait states, rdy_low drives ready=0
   // throughout, already = acceptance edge has passed, chain = present the
   // next request during this transaction.
   task automatic txn(input logic [2:0] t, input logic [19:0] a, input logic [7:0] d,
                      input int w, input logic [7:0] din, input bit rdy_low,
                      input bit already, input bit chain, input logic [2:0] nt,
                      input logic [19:0] na, input logic [7:0] nd, output int vld_at);
      int last;
      last   = 3 + w;
      vld_at = -1;
      if (!already) begin
         req_valid = 1'b1;
         req_type  = t;
         req_addr  = a;
         req_wdata = d;
         @(posedge clk); #1;
      end
      req_valid = chain;
      if (chain) begin
         req_type  = nt;
         req_addr  = na;
         req_wdata = nd;
      end
      for (int i = 0; i <= last; i++) begin
         exp_o  = cyc_exp(t, a, d, din, i, last);
         exp_on = 1'b1;
         ready  = rdy_low ? 1'b0 : ((i < 2 || i >= 2 + w) ? 1'b1 : 1'b0);
         ad_in  = (i == 2 + w) ? din : ~din;
         @(negedge clk);
         if (rsp_valid === 1'b1 && vld_at < 0) vld_at = i;
         @(posedge clk); #1;
      end
      if (!((t == 3'b010) || (t == 3'b110))) model_rdata = (t == 3'b011) ? 8'h00 : din;
      model_err = 1'b0;
      ready     = 1'b1;
      if (!chain) exp_o = idle_exp();
   endtask

   task automatic idle(input int n);
      exp_o  = idle_exp();
      exp_on = 1'b1;
      repeat (n) begin @(posedge clk); #1; end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
      $fatal(1);
   end

   initial begin
      int v, v2, c0, seen;
      reset = 1'b1; req_valid = 1'b0; req_type = 3'b000; req_addr = '0;
      req_wdata = '0; ready = 1'b1; ad_in = 8'h00;
      #1;
      check("rst_s_n",       32'(s_n),       32'h7);
      check("rst_ad_oe",     32'(ad_oe),     32'h0);
      check("rst_ad_out",    32'(ad_out),    32'h0);
      check("rst_a_hi",      32'(a_hi),      32'h0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      check("rst_rsp_rdata", 32'(rsp_rdata), 32'h0);
      check("rst_rsp_err",   32'(rsp_err),   32'h0);
      check("rst_req_ready", 32'(req_ready), 32'h0);
      repeat (2) begin @(posedge clk); #1; end
      reset = 1'b0;
      check("post_rst_ready_gate", 32'(req_ready), 32'h0);
      @(posedge clk); #1;
      idle(2);

      // Passive type is never accepted.
      req_valid = 1'b1; req_type = 3'b111; req_addr = 20'h12345;
      idle(3);
      req_valid = 1'b0;

      // IO write 0x00021 <- FF, no waits.
      txn(3'b010, 20'h00021, 8'hFF, 0, 8'h00, 0, 0, 0, 3'b0, '0, '0, v);
      check("iowr_valid_clock", 32'(v), 32'd3);
      idle(1);

      // Mem read 0xF0000 with two wait states, data A5.
      txn(3'b101, 20'hF0000, 8'h00, 2, 8'hA5, 0, 0, 0, 3'b0, '0, '0, v);
      check("memrd_valid_clock", 32'(v), 32'd5);
      check("memrd_rdata", 32'(rsp_rdata), 32'hA5);
      idle(1);

      // Back-to-back fetch then mem write with req_valid held.
      c0 = cyc;
      txn(3'b100, 20'h12345, 8'h00, 0, 8'h3C, 0, 0, 1, 3'b110, 20'hABCDE, 8'h5A, v);
      txn(3'b110, 20'hABCDE, 8'h5A, 0, 8'h00, 0, 1, 0, 3'b0, '0, '0, v2);
      check("b2b_clocks", 32'(cyc - c0), 32'd9);
      check("b2b_wr_valid_clock", 32'(v2), 32'd3);
      idle(1);

      // IO read and INTA with one wait state each.
      txn(3'b001, 20'h003F8, 8'h00, 1, 8'h96, 0, 0, 0, 3'b0, '0, '0, v);
      txn(3'b000, 20'h00000, 8'h00, 1, 8'h08, 0, 0, 0, 3'b0, '0, '0, v);
      check("inta_rdata", 32'(rsp_rdata), 32'h08);

      // Halt with ready stuck low.
      txn(3'b011, 20'h55AA0, 8'h77, 0, 8'hEE, 1, 0, 0, 3'b0, '0, '0, v);
      check("halt_valid_clock", 32'(v), 32'd3);
      check("halt_rdata", 32'(rsp_rdata), 32'h00);
      idle(1);

      // Reset while in TW.
      exp_on = 1'b0;
      req_valid = 1'b1; req_type = 3'b101; req_addr = 20'h12345;
      @(posedge clk); #1;
      req_valid = 1'b0; ready = 1'b0;
      repeat (4) begin @(posedge clk); #1; end
      check("tw_s_n_before_reset", 32'(s_n), 32'h5);
      #2 reset = 1'b1;
      #1;
      check("rst_mid_s_n",       32'(s_n),       32'h7);
      check("rst_mid_ad_oe",     32'(ad_oe),     32'h0);
      check("rst_mid_rsp_valid", 32'(rsp_valid), 32'h0);
      check("rst_mid_req_ready", 32'(req_ready), 32'h0);
      seen = 0;
      repeat (2) begin @(posedge clk); #1; if (rsp_valid !== 1'b0) seen++; end
      reset = 1'b0; ready = 1'b1;
      model_rdata = 8'h00; model_err = 1'b0;
      req_valid = 1'b1; req_type = 3'b001; req_addr = 20'h00060; ad_in = 8'h00;
      check("rst_release_gate", 32'(req_ready), 32'h0);
      @(posedge clk); #1;
      if (rsp_valid !== 1'b0) seen++;
      check("rst_no_rsp_valid", 32'(seen), 32'd0);
      check("rst_release_still_ti", 32'(s_n), 32'h7);
      idle(0);
      txn(3'b001, 20'h00060, 8'h00, 0, 8'h1E, 0, 0, 0, 3'b0, '0, '0, v);
      check("after_reset_valid_clock", 32'(v), 32'd3);
      check("after_reset_rdata", 32'(rsp_rdata), 32'h1E);
      idle(1);

      // Ready stuck low on a memory read.
      exp_on = 1'b0;
      req_valid = 1'b1; req_type = 3'b101; req_addr = 20'hC0DE0;
      @(posedge clk); #1;
      req_valid = 1'b0; ready = 1'b0; ad_in = 8'h42;
`ifdef BUS_WAIT_TIMEOUT_EN
      v = -1;
      for (int i = 0; i < 400 && v < 0; i++) begin
         @(negedge clk);
         if (rsp_valid === 1'b1) v = i;
         @(posedge clk); #1;
      end
      check("timeout_valid_clock", 32'(v), 32'd258);
      check("timeout_err",   32'(rsp_err),   32'h1);
      check("timeout_rdata", 32'(rsp_rdata), 32'hFF);
      ready = 1'b1;
      model_rdata = 8'hFF; model_err = 1'b1;
      idle(2);
      txn(3'b101, 20'h00100, 8'h00, 0, 8'h81, 0, 0, 0, 3'b0, '0, '0, v);
      check("post_timeout_rdata", 32'(rsp_rdata), 32'h81);
`else
      seen = 0;
      repeat (300) begin
         @(negedge clk);
         if (rsp_valid !== 1'b0) seen++;
         @(posedge clk); #1;
      end
      check("no_timeout_valid", 32'(seen), 32'd0);
      check("no_timeout_s_n",   32'(s_n),  32'h5);
      check("no_timeout_err",   32'(rsp_err), 32'h0);
      reset = 1'b1; #1; reset = 1'b0;
      ready = 1'b1; model_rdata = 8'h00; model_err = 1'b0;
      @(posedge clk); #1;
      idle(1);
      txn(3'b101, 20'h00100, 8'h00, 0, 8'h81, 0, 0, 0, 3'b0, '0, '0, v);
      check("post_stuck_rdata", 32'(rsp_rdata), 32'h81);
`endif
      idle(2);
      exp_on = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
